// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the hardwired CPU control unit:
// opcodes, ALU codes, sequencer states and MDR source selects.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;

    localparam logic [1:0] MDR_SRC_BUS = 2'b00;
    localparam logic [1:0] MDR_SRC_MEM = 2'b01;
    localparam logic [1:0] MDR_SRC_IMM = 2'b10;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ADDI, CLS_RTYPE, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_e;

    function automatic op_class_e classify(input logic [4:0] op);
        case (op)
            OP_LD:   return CLS_LD;
            OP_LDI:  return CLS_LDI;
            OP_ST:   return CLS_ST;
            OP_ADDI: return CLS_ADDI;
            OP_ADD, OP_SUB, OP_AND, OP_OR: return CLS_RTYPE;
            OP_NOP:  return CLS_NOP;
            OP_HALT: return CLS_HALT;
            default: return CLS_ILLEGAL;
        endcase
    endfunction

    // Immediate-form instructions all compute base + constant, hence ADD.
    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Memory wait-state counter: reloads to MEM_LATENCY-1 on entry to a memory
// step, counts down and saturates at zero.
module ctrl_wait_counter #(
    parameter int MEM_LATENCY = 1,
    localparam int CW = $clog2(MEM_LATENCY + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic first,
    output logic done
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LATENCY - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done  = (count_q == '0);
    assign first = (count_q == LOAD_VAL);

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired Moore control unit: fetch T0-T2, opcode-directed execute T3-T7,
// memory steps stretched by the wait counter, halt and illegal-opcode handling.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_WIDTH       = 32,
    parameter int OP_WIDTH       = 5,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int MEM_LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IR_WIDTH-1:0]       ir,
    output logic                      PCout,
    output logic                      PCin,
    output logic                      IncPc,
    output logic                      MARin,
    output logic                      MDRin,
    output logic                      MDRout,
    output logic [1:0]                mdr_read,
    output logic                      read,
    output logic                      write,
    output logic                      IRin,
    output logic                      Yin,
    output logic                      Zlowin,
    output logic                      Zlowout,
    output logic [ALU_CTRL_WIDTH-1:0] control,
    output logic                      Gra,
    output logic                      Grb,
    output logic                      Grc,
    output logic                      Rin,
    output logic                      Rout,
    output logic                      BAout,
    output logic                      Cout,
    output logic                      run,
    output logic                      illegal,
    output state_e                    dbg_state
);

    state_e    state_q;
    state_e    state_d;
    op_class_e cls;
    logic [OP_WIDTH-1:0] op;
    logic      wait_load;
    logic      wait_first;
    logic      wait_done;
    logic      unused_ir;

    assign op        = ir[IR_WIDTH-1 -: OP_WIDTH];
    assign cls       = classify(5'(op));
    assign unused_ir = ^ir[IR_WIDTH-OP_WIDTH-1:0];
    assign dbg_state = state_q;

    // Reload only when stepping into a state that may touch memory.
    assign wait_load = (state_d != state_q) &&
                       (state_d == S_T1 || state_d == S_T6 || state_d == S_T7);

    ctrl_wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
        .clk   (clk),
        .reset (reset),
        .load  (wait_load),
        .first (wait_first),
        .done  (wait_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (wait_done) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                case (cls)
                    CLS_NOP, CLS_ILLEGAL: state_d = S_T0;
                    CLS_HALT:             state_d = S_HALT;
                    default:              state_d = S_T4;
                endcase
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (cls == CLS_LD || cls == CLS_ST) ? S_T6 : S_T0;
            S_T6:    if (cls != CLS_LD || wait_done) state_d = S_T7;
            S_T7:    if (cls != CLS_ST || wait_done) state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPc    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        mdr_read = MDR_SRC_BUS;
        read     = 1'b0;
        write    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zlowout  = 1'b0;
        control  = '0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        BAout    = 1'b0;
        Cout     = 1'b0;
        illegal  = 1'b0;
        run      = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPc  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                read     = 1'b1;
                MDRin    = 1'b1;
                mdr_read = MDR_SRC_MEM;
                // The incremented PC is written back once, not per wait cycle.
                if (wait_first) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_LD, CLS_LDI, CLS_ST, CLS_ADDI: begin
                        Grb   = 1'b1;
                        BAout = 1'b1;
                        Yin   = 1'b1;
                    end
                    CLS_RTYPE: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    CLS_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                Zlowin  = 1'b1;
                control = ALU_CTRL_WIDTH'(alu_code(5'(op)));
                if (cls == CLS_RTYPE) begin
                    Grc  = 1'b1;
                    Rout = 1'b1;
                end else begin
                    Cout = 1'b1;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (cls == CLS_LD || cls == CLS_ST) begin
                    MARin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (cls == CLS_LD) begin
                    read     = 1'b1;
                    mdr_read = MDR_SRC_MEM;
                end else begin
                    Gra   = 1'b1;
                    BAout = 1'b1;
                end
            end
            S_T7: begin
                if (cls == CLS_LD) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else begin
                    write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: three instances (MEM_LATENCY 1..3) driven with
// directed and random instructions against a cycle-script reference model.
module tb_cpu_control_unit;

    localparam int OW = 27;
    localparam int P_COUT = 0, P_BAOUT = 1, P_ROUT = 2, P_RIN = 3, P_GRC = 4;
    localparam int P_GRB = 5, P_GRA = 6, P_ZLOWOUT = 7, P_ZLOWIN = 8, P_YIN = 9;
    localparam int P_IRIN = 10, P_WRITE = 11, P_READ = 12, P_MDROUT = 13;
    localparam int P_MDRIN = 14, P_MARIN = 15, P_INCPC = 16, P_PCIN = 17;
    localparam int P_PCOUT = 18, P_ILLEGAL = 25, P_RUN = 26;

    localparam logic [OW-1:0] M_COUT    = OW'(1) << P_COUT;
    localparam logic [OW-1:0] M_BAOUT   = OW'(1) << P_BAOUT;
    localparam logic [OW-1:0] M_ROUT    = OW'(1) << P_ROUT;
    localparam logic [OW-1:0] M_RIN     = OW'(1) << P_RIN;
    localparam logic [OW-1:0] M_GRC     = OW'(1) << P_GRC;
    localparam logic [OW-1:0] M_GRB     = OW'(1) << P_GRB;
    localparam logic [OW-1:0] M_GRA     = OW'(1) << P_GRA;
    localparam logic [OW-1:0] M_ZLOWOUT = OW'(1) << P_ZLOWOUT;
    localparam logic [OW-1:0] M_ZLOWIN  = OW'(1) << P_ZLOWIN;
    localparam logic [OW-1:0] M_YIN     = OW'(1) << P_YIN;
    localparam logic [OW-1:0] M_IRIN    = OW'(1) << P_IRIN;
    localparam logic [OW-1:0] M_WRITE   = OW'(1) << P_WRITE;
    localparam logic [OW-1:0] M_READ    = OW'(1) << P_READ;
    localparam logic [OW-1:0] M_MDROUT  = OW'(1) << P_MDROUT;
    localparam logic [OW-1:0] M_MDRIN   = OW'(1) << P_MDRIN;
    localparam logic [OW-1:0] M_MARIN   = OW'(1) << P_MARIN;
    localparam logic [OW-1:0] M_INCPC   = OW'(1) << P_INCPC;
    localparam logic [OW-1:0] M_PCIN    = OW'(1) << P_PCIN;
    localparam logic [OW-1:0] M_PCOUT   = OW'(1) << P_PCOUT;
    localparam logic [OW-1:0] M_MDRMEM  = OW'(1) << 19;
    localparam logic [OW-1:0] M_ILLEGAL = OW'(1) << P_ILLEGAL;
    localparam logic [OW-1:0] M_RUN     = OW'(1) << P_RUN;
    localparam logic [OW-1:0] W_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;

    localparam int C_LD = 0, C_LDI = 1, C_ST = 2, C_ADDI = 3, C_R = 4;
    localparam int C_NOP = 5, C_HALT = 6, C_ILL = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ir = '0;
    wire  [OW-1:0] obs [1:3];

    logic [OW-1:0] last_obs;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] log_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, rd, wr, ir_in;
        logic y_in, zlow_in, zlow_out, gra, grb, grc, r_in, r_out, ba_out, c_out;
        logic run_o, illegal_o;
        logic [1:0] mdr_sel;
        logic [3:0] alu_ctrl;
        cpu_ctrl_pkg::state_e unused_state;

        cpu_control_unit #(.MEM_LATENCY(g)) u_dut (
            .clk(clk), .reset(reset), .ir(ir),
            .PCout(pc_out), .PCin(pc_in), .IncPc(inc_pc),
            .MARin(mar_in), .MDRin(mdr_in), .MDRout(mdr_out), .mdr_read(mdr_sel),
            .read(rd), .write(wr), .IRin(ir_in), .Yin(y_in),
            .Zlowin(zlow_in), .Zlowout(zlow_out), .control(alu_ctrl),
            .Gra(gra), .Grb(grb), .Grc(grc), .Rin(r_in), .Rout(r_out),
            .BAout(ba_out), .Cout(c_out), .run(run_o), .illegal(illegal_o),
            .dbg_state(unused_state)
        );

        assign obs[g] = {run_o, illegal_o, alu_ctrl, mdr_sel, pc_out, pc_in, inc_pc,
                         mar_in, mdr_in, mdr_out, rd, wr, ir_in, y_in, zlow_in,
                         zlow_out, gra, grb, grc, r_in, r_out, ba_out, c_out};
    end

    // ---------------- reference model ----------------
    function automatic int op_class(input logic [4:0] op);
        case (op)
            5'b00000: return C_LD;
            5'b00001: return C_LDI;
            5'b00010: return C_ST;
            5'b01100: return C_ADDI;
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return C_R;
            5'b11010: return C_NOP;
            5'b11011: return C_HALT;
            default:  return C_ILL;
        endcase
    endfunction

    function automatic logic [OW-1:0] ctrl_field(input logic [4:0] op);
        logic [OW-1:0] r;
        r = '0;
        case (op)
            5'b00100: r[24:21] = 4'd3;
            5'b00101: r[24:21] = 4'd4;
            5'b00110: r[24:21] = 4'd5;
            default:  r[24:21] = 4'd2;
        endcase
        return r;
    endfunction

    function automatic int spec_len(input logic [4:0] op, input int lat);
        case (op_class(op))
            C_NOP, C_ILL: return 3 + lat;
            C_LD, C_ST:   return 6 + 2 * lat;
            default:      return 5 + lat;
        endcase
    endfunction

    // Expected strobe word for every cycle of one instruction, T0 first.
    task automatic build_script(input logic [4:0] op, input int lat);
        int cls;
        cls = op_class(op);
        exp_q.delete();
        exp_q.push_back(W_T0);
        for (int i = 0; i < lat; i++)
            exp_q.push_back(M_RUN | M_READ | M_MDRIN | M_MDRMEM |
                            ((i == 0) ? (M_ZLOWOUT | M_PCIN) : '0));
        exp_q.push_back(M_RUN | M_MDROUT | M_IRIN);
        case (cls)
            C_NOP, C_HALT: exp_q.push_back(M_RUN);
            C_ILL:         exp_q.push_back(M_RUN | M_ILLEGAL);
            C_R:           exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
            default:       exp_q.push_back(M_RUN | M_GRB | M_BAOUT | M_YIN);
        endcase
        if (cls <= C_R) begin
            exp_q.push_back(M_RUN | M_ZLOWIN | ctrl_field(op) |
                            ((cls == C_R) ? (M_GRC | M_ROUT) : M_COUT));
            if (cls == C_LD || cls == C_ST)
                exp_q.push_back(M_RUN | M_ZLOWOUT | M_MARIN);
            else
                exp_q.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
            if (cls == C_LD) begin
                for (int i = 0; i < lat; i++)
                    exp_q.push_back(M_RUN | M_READ | M_MDRIN | M_MDRMEM);
                exp_q.push_back(M_RUN | M_MDROUT | M_GRA | M_RIN);
            end
            if (cls == C_ST) begin
                exp_q.push_back(M_RUN | M_GRA | M_BAOUT | M_MDRIN);
                for (int i = 0; i < lat; i++) exp_q.push_back(M_RUN | M_WRITE);
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input int sel);
        @(posedge clk);
        #1;
        last_obs = obs[sel];
    endtask

    task automatic do_reset(input int sel);
        reset = 1'b1;
        ir = '0;
        tick(sel);
        reset = 1'b0;
        tick(sel);
    endtask

    // Called while the selected instance shows T0; returns at its next T0.
    task automatic run_instr(input int sel, input logic [31:0] ir_v,
                             input string tag, output int len);
        logic [OW-1:0] exp_w;
        logic is_halt;
        int idx;
        ir = ir_v;
        is_halt = (op_class(ir_v[31:27]) == C_HALT);
        build_script(ir_v[31:27], sel);
        log_q.delete();
        len = 0;
        idx = 0;
        while (1) begin
            log_q.push_back(last_obs);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                n_tests++;
                if (last_obs !== exp_w) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got %h expected %h", tag, idx, last_obs, exp_w);
                end
            end
            if (is_halt && exp_q.size() == 0) break;
            tick(sel);
            len++;
            idx++;
            if (last_obs === W_T0) break;
            if (len > 40) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s timeout: no return to T0 after %0d cycles", tag, len);
                break;
            end
        end
        if (!is_halt) begin
            n_tests++;
            if (len != spec_len(ir_v[31:27], sel)) begin
                n_fail++;
                $display("FAIL %s length: got %0d expected %0d", tag, len, spec_len(ir_v[31:27], sel));
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int s = 1; s <= 3; s++) begin
            reset = 1'b1;
            for (int c = 0; c < 2; c++) begin
                tick(s);
                n_tests++;
                if (last_obs !== '0) begin
                    n_fail++;
                    $display("FAIL reset_zero L=%0d: got %h expected 0", s, last_obs);
                end
            end
            reset = 1'b0;
            tick(s);
            n_tests++;
            if (last_obs !== W_T0) begin
                n_fail++;
                $display("FAIL reset_t0 L=%0d: got %h expected %h", s, last_obs, W_T0);
            end
        end
    endtask

    task automatic test_ldi();
        int len;
        do_reset(1);
        run_instr(1, 32'h09000015, "ldi", len);
        n_tests++;
        if (len != 6 || log_q.size() < 6) begin
            n_fail++;
            $display("FAIL ldi_len: got %0d expected 6", len);
        end else begin
            n_tests++;
            if (log_q[4][24:21] !== 4'd2 || log_q[4][P_COUT] !== 1'b1) begin
                n_fail++;
                $display("FAIL ldi_t4: got ctrl %0d cout %b expected 2 1", log_q[4][24:21], log_q[4][P_COUT]);
            end
            n_tests++;
            if (log_q[5][P_GRA] !== 1'b1 || log_q[5][P_RIN] !== 1'b1) begin
                n_fail++;
                $display("FAIL ldi_t5: got gra %b rin %b expected 1 1", log_q[5][P_GRA], log_q[5][P_RIN]);
            end
        end
    endtask

    task automatic test_st();
        int len, wcnt, first_w, both;
        do_reset(3);
        run_instr(3, {5'b00010, 4'd3, 4'd1, 19'd90}, "st", len);
        wcnt = 0; first_w = -1; both = 0;
        foreach (log_q[i]) begin
            if (log_q[i][P_WRITE]) begin
                wcnt++;
                if (first_w < 0) first_w = i;
            end
            if (log_q[i][P_WRITE] && log_q[i][P_READ]) both++;
        end
        n_tests++;
        if (wcnt != 3 || first_w < 1 || !(log_q[first_w+1][P_WRITE] && log_q[first_w+2][P_WRITE])) begin
            n_fail++;
            $display("FAIL st_write: got %0d cycles from %0d expected 3 consecutive", wcnt, first_w);
        end else begin
            n_tests++;
            if ((log_q[first_w-1] & (M_GRA | M_BAOUT | M_MDRIN)) !== (M_GRA | M_BAOUT | M_MDRIN)) begin
                n_fail++;
                $display("FAIL st_t6: got %h expected Gra BAout MDRin set", log_q[first_w-1]);
            end
        end
        n_tests++;
        if (both != 0) begin
            n_fail++;
            $display("FAIL st_rw_overlap: got %0d cycles expected 0", both);
        end
        n_tests++;
        if (len != 12) begin
            n_fail++;
            $display("FAIL st_len: got %0d expected 12", len);
        end
    endtask

    task automatic test_ld();
        int len, rcnt;
        do_reset(2);
        run_instr(2, {5'b00000, 4'd0, 4'd0, 19'h55}, "ld", len);
        rcnt = 0;
        foreach (log_q[i]) if (log_q[i][P_READ]) rcnt++;
        n_tests++;
        if (rcnt != 4 || log_q.size() < 10 || !(log_q[1][P_READ] && log_q[2][P_READ] &&
                                                log_q[7][P_READ] && log_q[8][P_READ])) begin
            n_fail++;
            $display("FAIL ld_read: got %0d read cycles expected 4 at 1,2,7,8", rcnt);
        end else begin
            n_tests++;
            if ((log_q[9] & (M_MDROUT | M_GRA | M_RIN)) !== (M_MDROUT | M_GRA | M_RIN)) begin
                n_fail++;
                $display("FAIL ld_t7: got %h expected MDRout Gra Rin set", log_q[9]);
            end
        end
        n_tests++;
        if (len != 10) begin
            n_fail++;
            $display("FAIL ld_len: got %0d expected 10", len);
        end
    endtask

    task automatic test_alu();
        int len, t4;
        logic [4:0] ops [4];
        logic [3:0] codes [4];
        ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110};
        codes = '{4'd2, 4'd3, 4'd4, 4'd5};
        for (int s = 1; s <= 3; s++) begin
            do_reset(s);
            t4 = s + 3;
            for (int k = 0; k < 4; k++) begin
                run_instr(s, {ops[k], 4'(k + 3), 4'd1, 4'd2, 15'($urandom)}, "alu", len);
                n_tests++;
                if (log_q.size() <= t4 || log_q[t4][24:21] !== codes[k] ||
                    !log_q[t4][P_GRC] || !log_q[t4][P_ROUT]) begin
                    n_fail++;
                    $display("FAIL alu_t4 op %b L=%0d: got %h expected ctrl %0d with Grc Rout",
                             ops[k], s, (log_q.size() > t4) ? log_q[t4] : '0, codes[k]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int len, icnt, bad;
        do_reset(2);
        run_instr(2, {5'b11111, 27'h0123456}, "illegal", len);
        icnt = 0; bad = 0;
        foreach (log_q[i]) begin
            if (log_q[i][P_ILLEGAL]) icnt++;
            if (log_q[i][P_RIN] || log_q[i][P_WRITE]) bad++;
        end
        n_tests++;
        if (icnt != 1 || log_q.size() < 5 || !log_q[4][P_ILLEGAL]) begin
            n_fail++;
            $display("FAIL illegal_pulse: got %0d cycles expected 1 in T3", icnt);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL illegal_side_effect: got %0d Rin/write cycles expected 0", bad);
        end
        n_tests++;
        if (last_obs !== W_T0 || len != 5) begin
            n_fail++;
            $display("FAIL illegal_return: got len %0d expected 5 ending at T0", len);
        end
    endtask

    task automatic test_halt();
        int len, bad;
        do_reset(1);
        run_instr(1, {5'b11011, 27'h0}, "halt", len);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (last_obs !== '0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt_quiet: got %0d non-zero cycles expected 0", bad);
        end
        do_reset(1);
        n_tests++;
        if (last_obs !== W_T0) begin
            n_fail++;
            $display("FAIL halt_restart: got %h expected %h", last_obs, W_T0);
        end
    endtask

    task automatic test_reset_mid_st();
        int seen;
        do_reset(3);
        ir = {5'b00010, 4'd2, 4'd5, 19'd7};
        seen = 0;
        for (int c = 0; c < 30 && seen == 0; c++) begin
            tick(3);
            if (last_obs[P_WRITE]) seen = 1;
        end
        n_tests++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL midst_write_seen: got none expected write within 30 cycles");
        end
        reset = 1'b1;
        tick(3);
        n_tests++;
        if (last_obs !== '0) begin
            n_fail++;
            $display("FAIL midst_abort: got %h expected 0", last_obs);
        end
        reset = 1'b0;
        tick(3);
        n_tests++;
        if (last_obs !== W_T0) begin
            n_fail++;
            $display("FAIL midst_refetch: got %h expected %h", last_obs, W_T0);
        end
    endtask

    task automatic test_back_to_back();
        int len;
        logic [31:0] r;
        logic [4:0] op;
        logic [4:0] valid_ops [9];
        valid_ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                      5'b00101, 5'b00110, 5'b01100, 5'b11010};
        for (int s = 1; s <= 3; s++) begin
            do_reset(s);
            for (int k = 0; k < 12; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    op = 5'($urandom);
                    while (op_class(op) != C_ILL) op = 5'($urandom);
                end else begin
                    op = valid_ops[$urandom_range(0, 8)];
                end
                r = $urandom();
                run_instr(s, {op, r[26:0]}, "random", len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_st();
        test_ld();
        test_alu();
        test_illegal();
        test_halt();
        test_reset_mid_st();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
